three_input_debouncer: RTL and testbench

//  Front-end conditioning stage for the lab-board 3-input AND gate.

---
 rtl/three_input_debouncer.sv | 105 ++++++++++
 tb/tb_three_input_debouncer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/three_input_debouncer.sv
// Three-channel switch conditioner: 2-FF synchroniser plus an independent
// stability counter per channel, feeding registered a/b/c and a one-cycle
// 'changed' strobe whenever any cleaned level updates.
module three_input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic a,
  output logic b,
  output logic c,
  output logic changed
);

  localparam int unsigned NCH = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dbnc_state_e;

  // Channel index 0/1/2 maps to a/b/c throughout.
  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q, s1_d;
  logic [NCH-1:0]   s2_q, s2_d;
  logic [NCH-1:0]   x_q,  x_d;
  logic [NCH-1:0]   upd;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic             changed_q, changed_d;
  dbnc_state_e      state [NCH];

  assign raw = {c_in, b_in, a_in};

  // State register: all synchroniser, counter, level and strobe flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      x_q       <= '0;
      changed_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      x_q       <= x_d;
      changed_q <= changed_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Channel state is implied by the synchronised level disagreeing with the output.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      state[i] = (s2_q[i] != x_q[i]) ? COUNT : IDLE;
    end
  end

  // Next-state: synchroniser shift, counter advance/restart, level update on terminal count.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    x_d  = x_q;
    upd  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      case (state[i])
        IDLE: begin
          cnt_d[i] = '0;
        end
        COUNT: begin
          if (cnt_q[i] == CNT_LAST) begin
            upd[i]   = 1'b1;
            x_d[i]   = s2_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
    changed_d = |upd;
  end

  // Outputs are taken straight from flops.
  always_comb begin
    a       = x_q[0];
    b       = x_q[1];
    c       = x_q[2];
    changed = changed_q;
  end

endmodule

// File: tb/tb_three_input_debouncer.sv
// Scoreboard bench for three_input_debouncer at STABLE_CYCLES=4.
// Expected {a,b,c,changed} per edge is queued when stimulus is planned and
// popped/compared 1ns after each rising edge.
module tb_three_input_debouncer;

  logic clk;
  logic rst;
  logic a_in, b_in, c_in;
  logic a, b, c, changed;

  int unsigned checks;
  int unsigned failures;
  logic [3:0]  exp_q [$];

  three_input_debouncer #(
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .c_in   (c_in),
    .a      (a),
    .b      (b),
    .c      (c),
    .changed(changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    c_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp, obs;
    rst  = 1'b1;
    a_in = 1'b1;
    b_in = 1'b1;
    c_in = 1'b1;
    for (int k = 1; k <= 3; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) begin
        a_in = 1'b0;
        b_in = 1'b0;
        c_in = 1'b0;
      end
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset k=%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
    rst = 1'b0;
    // Nothing latched during reset: outputs stay low afterwards.
    for (int k = 1; k <= 8; k++) exp_q.push_back(4'b0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_after k=%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [3:0] exp, obs;
    apply_reset();
    a_in = 1'b1;
    for (int k = 1; k <= 8; k++)
      exp_q.push_back({(k >= 6) ? 1'b1 : 1'b0, 1'b0, 1'b0, (k == 6) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rise_a E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_fall();
    logic [3:0] exp, obs;
    a_in = 1'b0;
    for (int k = 1; k <= 8; k++)
      exp_q.push_back({(k < 6) ? 1'b1 : 1'b0, 1'b0, 1'b0, (k == 6) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL fall_a E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] exp, obs;
    apply_reset();
    for (int w = 1; w <= 3; w += 2) begin
      for (int k = 1; k <= 10; k++) exp_q.push_back(4'b0000);
      for (int k = 1; k <= 10; k++) begin
        b_in = (k <= w) ? 1'b1 : 1'b0;
        tick();
        exp = exp_q.pop_front();
        obs = {a, b, c, changed};
        checks++;
        if (obs !== exp) begin
          failures++;
          $display("FAIL glitch_w%0d E%0d abc_chg got=%b want=%b", w, k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_min_pulse();
    logic [3:0] exp, obs;
    apply_reset();
    for (int k = 1; k <= 12; k++)
      exp_q.push_back({1'b0, (k >= 6 && k <= 9) ? 1'b1 : 1'b0, 1'b0,
                       (k == 6 || k == 10) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 12; k++) begin
      b_in = (k <= 4) ? 1'b1 : 1'b0;
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL min_pulse E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_all_three();
    logic [3:0] exp, obs;
    logic       d_obs;
    apply_reset();
    a_in = 1'b1;
    b_in = 1'b1;
    c_in = 1'b1;
    for (int k = 1; k <= 8; k++)
      exp_q.push_back({{3{(k >= 6) ? 1'b1 : 1'b0}}, (k == 6) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      d_obs = a & b & c;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL all_three E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
      checks++;
      if (d_obs !== exp[1]) begin
        failures++;
        $display("FAIL gate_d E%0d got=%b want=%b", k, d_obs, exp[1]);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic [3:0] exp, obs;
    apply_reset();
    c_in = 1'b1;
    for (int k = 1; k <= 11; k++)
      exp_q.push_back({1'b0, 1'b0, (k >= 10) ? 1'b1 : 1'b0, (k == 10) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 11; k++) begin
      rst = (k == 4) ? 1'b1 : 1'b0;
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rst_mid E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_bounce();
    logic [3:0] exp, obs;
    logic [6:1] pat;
    apply_reset();
    pat = 6'b111101;  // bit k is c_in before edge k: 1,0,1,1,1,1
    for (int k = 1; k <= 10; k++)
      exp_q.push_back({1'b0, 1'b0, (k >= 8) ? 1'b1 : 1'b0, (k == 8) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 10; k++) begin
      c_in = (k <= 6) ? pat[k] : 1'b1;
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL bounce E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp, obs;
    apply_reset();
    for (int k = 1; k <= 10; k++)
      exp_q.push_back({(k >= 6) ? 1'b1 : 1'b0, (k >= 8) ? 1'b1 : 1'b0, 1'b0,
                       (k == 6 || k == 8) ? 1'b1 : 1'b0});
    for (int k = 1; k <= 10; k++) begin
      a_in = 1'b1;
      b_in = (k >= 3) ? 1'b1 : 1'b0;
      tick();
      exp = exp_q.pop_front();
      obs = {a, b, c, changed};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back E%0d abc_chg got=%b want=%b", k, obs, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    a_in = 1'b0;
    b_in = 1'b0;
    c_in = 1'b0;
    test_reset();
    test_single_rise();
    test_fall();
    test_glitch();
    test_min_pulse();
    test_all_three();
    test_reset_midcount();
    test_bounce();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
